// File: rtl/bnn_pkg.sv
// Shared types and widths for the bnn streaming host.
package bnn_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RD_ADDR,
    RD_WAIT,
    OUT
  } host_state_t;

  localparam int ACT_W  = 16;
  localparam int ADDR_W = 7;
  localparam int BETA_W = 3;

endpackage

// File: rtl/bnn_stream_host.sv
// Stream front/back end for the bnn core: loads one activation frame, starts the core,
// then reads the result words back out on a valid/ready stream.
module bnn_stream_host
  import bnn_pkg::*;
#(
  parameter int N_IN       = 64,
  parameter int N_OUT      = 8,
  parameter int IN_BASE    = 0,
  parameter int OUT_BASE   = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ACT_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BETA_W-1:0] beta_cfg,
  output logic [ACT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              bnn_start,
  output logic [BETA_W-1:0] bnn_beta,
  output logic [ACT_W-1:0]  bnn_data,
  output logic [ADDR_W-1:0] bnn_addr_wr,
  output logic              bnn_enb_wr,
  output logic [ADDR_W-1:0] bnn_addr_rd,
  input  logic [ACT_W-1:0]  bnn_act_out,
  input  logic              bnn_done
);

  if (N_IN < 1 || N_IN > 128) begin : g_chk_n_in
    $fatal(1, "bnn_stream_host: N_IN must be within 1..128");
  end
  if (N_OUT < 1 || N_OUT > 128) begin : g_chk_n_out
    $fatal(1, "bnn_stream_host: N_OUT must be within 1..128");
  end
  if (RD_LATENCY < 0 || RD_LATENCY > 7) begin : g_chk_lat
    $fatal(1, "bnn_stream_host: RD_LATENCY must fit the 3-bit latency counter");
  end

  localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
  localparam logic [7:0]        W_LAST     = 8'(N_IN - 1);
  localparam logic [7:0]        W_END      = 8'(N_IN);
  localparam logic [7:0]        R_LAST     = 8'(N_OUT - 1);
  localparam logic [2:0]        LAT        = 3'(RD_LATENCY);

  host_state_t       state_q, state_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [2:0]        lcnt_q, lcnt_d;
  logic              in_ready_q, in_ready_d;
  logic [ACT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              start_q, start_d;
  logic [BETA_W-1:0] beta_q, beta_d;
  logic [ACT_W-1:0]  wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic              enb_wr_q, enb_wr_d;
  logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      lcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      beta_q      <= '0;
      wdata_q     <= '0;
      addr_wr_q   <= IN_BASE_A;
      enb_wr_q    <= 1'b0;
      addr_rd_q   <= OUT_BASE_A;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      lcnt_q      <= lcnt_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
      beta_q      <= beta_d;
      wdata_q     <= wdata_d;
      addr_wr_q   <= addr_wr_d;
      enb_wr_q    <= enb_wr_d;
      addr_rd_q   <= addr_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    lcnt_d      = lcnt_q;
    in_ready_d  = in_ready_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    start_d     = 1'b0;
    beta_d      = beta_q;
    wdata_d     = wdata_q;
    addr_wr_d   = addr_wr_q;
    enb_wr_d    = 1'b0;
    addr_rd_d   = addr_rd_q;

    case (state_q)
      LOAD: begin
        // wcnt==N_IN is the cycle the last write is presented to the bnn input register;
        // start is raised so it lands one cycle after that write.
        if (wcnt_q == W_END) begin
          in_ready_d = 1'b0;
          start_d    = 1'b1;
          state_d    = START;
        end else begin
          in_ready_d = bnn_done;
          if (in_valid && in_ready_q) begin
            wdata_d   = in_data;
            addr_wr_d = IN_BASE_A + wcnt_q[ADDR_W-1:0];
            enb_wr_d  = 1'b1;
            wcnt_d    = wcnt_q + 8'd1;
            if (wcnt_q == 8'd0) begin
              beta_d = beta_cfg;
            end
            if (wcnt_q == W_LAST) begin
              in_ready_d = 1'b0;
            end
          end
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bnn_done) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bnn_done) begin
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        addr_rd_d = OUT_BASE_A + rcnt_q[ADDR_W-1:0];
        lcnt_d    = '0;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        if (lcnt_q == LAT) begin
          out_data_d  = bnn_act_out;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          lcnt_d = lcnt_q + 3'd1;
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (rcnt_q == R_LAST) begin
            rcnt_d     = '0;
            wcnt_d     = '0;
            in_ready_d = bnn_done;
            state_d    = LOAD;
          end else begin
            rcnt_d  = rcnt_q + 8'd1;
            state_d = RD_ADDR;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign in_ready    = in_ready_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != LOAD) || (wcnt_q != 8'd0);
  assign bnn_start   = start_q;
  assign bnn_beta    = beta_q;
  assign bnn_data    = wdata_q;
  assign bnn_addr_wr = addr_wr_q;
  assign bnn_enb_wr  = enb_wr_q;
  assign bnn_addr_rd = addr_rd_q;

endmodule

// File: tb/tb_bnn_stream_host.sv
// Bench for bnn_stream_host: a behavioural bnn (memory, busy window, 2-cycle read) around
// the host, random frames scored against results computed from the words sent.
module tb_bnn_stream_host;

  localparam int A_NIN  = 4;
  localparam int A_NOUT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  beta_cfg;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        bnn_start;
  logic [2:0]  bnn_beta;
  logic [15:0] bnn_data;
  logic [6:0]  bnn_addr_wr;
  logic        bnn_enb_wr;
  logic [6:0]  bnn_addr_rd;
  logic [15:0] bnn_act_out = '0;
  logic        bnn_done;

  logic [15:0] b_in_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [2:0]  b_beta_cfg;
  logic [15:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic        b_busy;
  logic        b_bnn_start;
  logic [2:0]  b_bnn_beta;
  logic [15:0] b_bnn_data;
  logic [6:0]  b_bnn_addr_wr;
  logic        b_bnn_enb_wr;
  logic [6:0]  b_bnn_addr_rd;
  logic [15:0] b_bnn_act_out;
  logic        b_bnn_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bnn_stream_host #(.N_IN(A_NIN), .N_OUT(A_NOUT), .IN_BASE(0), .OUT_BASE(64), .RD_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .beta_cfg(beta_cfg), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .bnn_start(bnn_start), .bnn_beta(bnn_beta), .bnn_data(bnn_data),
    .bnn_addr_wr(bnn_addr_wr), .bnn_enb_wr(bnn_enb_wr), .bnn_addr_rd(bnn_addr_rd),
    .bnn_act_out(bnn_act_out), .bnn_done(bnn_done)
  );

  bnn_stream_host #(.N_IN(4), .N_OUT(1), .IN_BASE(126), .OUT_BASE(64), .RD_LATENCY(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .beta_cfg(b_beta_cfg), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy), .bnn_start(b_bnn_start), .bnn_beta(b_bnn_beta), .bnn_data(b_bnn_data),
    .bnn_addr_wr(b_bnn_addr_wr), .bnn_enb_wr(b_bnn_enb_wr), .bnn_addr_rd(b_bnn_addr_rd),
    .bnn_act_out(b_bnn_act_out), .bnn_done(b_bnn_done)
  );

  // Behavioural bnn: result word j = (input word j XOR beta) + 3*j, ready after a random busy window.
  typedef struct {
    int         c;
    logic [6:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         wr_log[$];
  logic [6:0]  b_log[$];
  logic [15:0] mem [128];
  logic [6:0]  rd_p1 = '0;
  logic        m_done = 1'b1;
  int          m_cnt = 0;
  logic [2:0]  m_beta = '0;
  logic        hold_busy = 1'b0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          last_start_cyc = 0;
  int          ov_cnt = 0;

  assign bnn_done = m_done && !hold_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid) ov_cnt <= ov_cnt + 1;
    if (bnn_enb_wr) begin
      mem[bnn_addr_wr] <= bnn_data;
      wr_log.push_back('{c: cyc, a: bnn_addr_wr, d: bnn_data});
    end
    if (bnn_start) begin
      start_cnt      <= start_cnt + 1;
      last_start_cyc <= cyc;
      m_beta         <= bnn_beta;
      m_done         <= 1'b0;
      m_cnt          <= int'($urandom_range(3, 10));
    end else if (!m_done) begin
      if (m_cnt == 0) begin
        for (int j = 0; j < A_NOUT; j++)
          mem[7'(64 + j)] <= (mem[7'(j)] ^ {13'b0, m_beta}) + 16'(j * 3);
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    rd_p1       <= bnn_addr_rd;
    bnn_act_out <= mem[rd_p1];
  end

  always @(posedge clk) begin
    if (b_bnn_enb_wr) b_log.push_back(b_bnn_addr_wr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", bnn_start, 0);
    chk("rst_beta", bnn_beta, 0);
    chk("rst_bnn_data", bnn_data, 0);
    chk("rst_addr_wr", bnn_addr_wr, 0);
    chk("rst_enb_wr", bnn_enb_wr, 0);
    chk("rst_addr_rd", bnn_addr_rd, 64);
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    in_data = w;
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic run_frame(input bit gap, input bit stall, input logic [2:0] b0,
                           input logic [2:0] b1, input bit b2b);
    logic [15:0] words [A_NIN];
    logic [15:0] expv;
    logic [15:0] got;
    int w0, s0, n;
    bit ok;
    w0 = wr_log.size();
    s0 = start_cnt;
    beta_cfg = b0;
    for (int i = 0; i < A_NIN; i++) words[i] = 16'($urandom);
    for (int i = 0; i < A_NIN; i++) begin
      send_word(words[i], gap && ($urandom_range(0, 1) == 1 || i[0]), ok);
      chk("in_accept", ok, 1);
      if (i == 0) beta_cfg = b1;
      else chk("beta_hold", bnn_beta, b0);
    end
    tick();
    chk("wr_count", wr_log.size() - w0, A_NIN);
    if (wr_log.size() >= w0 + A_NIN) begin
      for (int i = 0; i < A_NIN; i++) begin
        chk("wr_addr", wr_log[w0 + i].a, i);
        chk("wr_data", wr_log[w0 + i].d, words[i]);
        if (b2b && i > 0) chk("wr_b2b", wr_log[w0 + i].c - wr_log[w0 + i - 1].c, 1);
      end
    end
    for (int j = 0; j < A_NOUT; j++) begin
      expv = (words[j] ^ {13'b0, b0}) + 16'(j * 3);
      out_ready = !(stall && j == 0);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("out_wait", out_valid, 1);
      got = out_data;
      if (stall && j == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_data", out_data, got);
          chk("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
      end
      chk("out_word", got, expv);
      tick();
      chk("out_valid_drop", out_valid, 0);
    end
    out_ready = 1'b1;
    chk("start_pulses", start_cnt - s0, 1);
    if (b2b && wr_log.size() >= w0 + A_NIN)
      chk("start_after_wr", last_start_cyc > wr_log[w0 + A_NIN - 1].c, 1);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, w0, ov0;
    bit ok;
    logic [6:0] ea;
    rst_n = 1'b1;
    in_data = '0; in_valid = 1'b0; beta_cfg = '0; out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_beta_cfg = 3'd1; b_out_ready = 1'b0;
    b_bnn_act_out = '0; b_bnn_done = 1'b1;
    #1 rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);

    // 1: back-to-back frame
    run_frame(1'b0, 1'b0, 3'($urandom), 3'($urandom), 1'b1);
    // 2: gapped input, stalled output
    run_frame(1'b1, 1'b1, 3'($urandom), 3'($urandom), 1'b0);
    // 3: beta changes after first word
    run_frame(1'b0, 1'b0, 3'd5, 3'd2, 1'b0);

    // 6: bnn busy from outside at frame begin
    hold_busy = 1'b1;
    tick();
    w0 = wr_log.size();
    in_data = 16'hBEEF;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_enb_wr", bnn_enb_wr, 0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("hold_no_write", wr_log.size() - w0, 0);
    hold_busy = 1'b0;
    tick();
    run_frame(1'b0, 1'b0, 3'($urandom), 3'($urandom), 1'b0);

    // 4: reset while waiting for the bnn to finish
    beta_cfg = 3'($urandom);
    for (int i = 0; i < A_NIN; i++) begin
      send_word(16'($urandom), 1'b0, ok);
      chk("r4_accept", ok, 1);
    end
    n = 0;
    while (bnn_done && n < 100) begin
      tick();
      n++;
    end
    chk("r4_bnn_busy", bnn_done, 0);
    tick();
    #2 rst_n = 1'b0;
    #1 reset_checks();
    @(negedge clk) rst_n = 1'b1;
    ov0 = ov_cnt;
    repeat (30) tick();
    chk("r4_no_partial", ov_cnt - ov0, 0);
    chk("r4_ready", in_ready, 1);
    run_frame(1'b0, 1'b0, 3'($urandom), 3'($urandom), 1'b1);

    for (int r = 0; r < 3; r++)
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 1'b0);

    // 5: write address wraps past 127
    b_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_data = 16'(i + 1);
      n = 0;
      @(negedge clk);
      while (!b_in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("wrap_ready", b_in_ready, 1);
      tick();
    end
    b_in_valid = 1'b0;
    tick();
    tick();
    chk("wrap_count", b_log.size(), 4);
    if (b_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        ea = 7'((126 + i) % 128);
        chk("wrap_addr", b_log[i], ea);
      end
    end
    chk("wrap_beta", b_bnn_beta, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
